// File: rtl/proof_mlcomb.sv
// proof_mlcomb: modular linear-combination sequencer.
// Computes sum(coef_k * dat_k) mod p over a stream of terms. Each term goes
// through an external small-coefficient modular multiplier, and the product
// is added into the accumulator with a single conditional subtract.
// Optional build macro: PROOF_MLCOMB_ZSKIP_EN. When it is defined, terms
// with coef = 0 bypass the multiplier entirely.
module proof_mlcomb (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [255:0] modp_i,
    input  logic         term_valid_i,
    output logic         term_ready_o,
    input  logic [3:0]   term_coef_i,
    input  logic [255:0] term_dat_i,
    input  logic         term_last_i,
    output logic         mstr_o,
    output logic [3:0]   coef_o,
    output logic [255:0] mdat_o,
    output logic [255:0] modp_o,
    input  logic         mend_i,
    input  logic [255:0] mult_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [255:0] sum_o,
    output logic [7:0]   term_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_T = 3'd1,
        S_MSTR   = 3'd2,
        S_MWAIT  = 3'd3,
        S_ADD    = 3'd4,
        S_RED    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [255:0]  modp_q,  modp_d;
    logic [3:0]    coef_q,  coef_d;
    logic [255:0]  mdat_q,  mdat_d;
    logic          last_q,  last_d;
    logic [7:0]    cnt_q,   cnt_d;
    logic [255:0]  mreg_q,  mreg_d;
    logic [256:0]  s_q,     s_d;
    logic [255:0]  acc_q,   acc_d;

    // Reduction helpers: the low 256 bits of s - p are exact whenever s >= p,
    // because the true difference is then below p < 2^256.
    logic          s_ge_p;
    logic [255:0]  s_minus_p;

    // Conditional-subtract datapath for the RED step.
    always_comb begin
        s_ge_p    = (s_q >= {1'b0, modp_q});
        s_minus_p = s_q[255:0] - modp_q;
    end

    // Next-state and register-update logic for the term sequencer.
    always_comb begin
        state_d = state_q;
        modp_d  = modp_q;
        coef_d  = coef_q;
        mdat_d  = mdat_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        mreg_d  = mreg_q;
        s_d     = s_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    modp_d  = modp_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_WAIT_T;
                end
            end
            S_WAIT_T: begin
                if (term_valid_i) begin
                    coef_d  = term_coef_i;
                    mdat_d  = term_dat_i;
                    last_d  = term_last_i;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef PROOF_MLCOMB_ZSKIP_EN
                    // A zero coefficient contributes nothing; skip the multiply.
                    if (term_coef_i == 4'd0) begin
                        state_d = term_last_i ? S_DONE : S_WAIT_T;
                    end else begin
                        state_d = S_MSTR;
                    end
`else
                    state_d = S_MSTR;
`endif
                end
            end
            S_MSTR: begin
                state_d = S_MWAIT;
            end
            S_MWAIT: begin
                if (mend_i) begin
                    mreg_d  = mult_i;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                s_d     = {1'b0, acc_q} + {1'b0, mreg_q};
                state_d = S_RED;
            end
            S_RED: begin
                acc_d   = s_ge_p ? s_minus_p : s_q[255:0];
                state_d = last_q ? S_DONE : S_WAIT_T;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            modp_q  <= '0;
            coef_q  <= '0;
            mdat_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            mreg_q  <= '0;
            s_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            modp_q  <= modp_d;
            coef_q  <= coef_d;
            mdat_q  <= mdat_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            mreg_q  <= mreg_d;
            s_q     <= s_d;
            acc_q   <= acc_d;
        end
    end

    // Outputs are decoded from state or taken straight from registers.
    always_comb begin
        term_ready_o = (state_q == S_WAIT_T);
        mstr_o       = (state_q == S_MSTR);
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        coef_o       = coef_q;
        mdat_o       = mdat_q;
        modp_o       = modp_q;
        sum_o        = acc_q;
        term_cnt_o   = cnt_q;
    end

endmodule

// File: tb/tb_proof_mlcomb.sv
// Testbench for proof_mlcomb: directed combinations with hand-computed sums,
// a behavioural 4-cycle multiplier, and a done_o-driven scoreboard monitor.
module tb_proof_mlcomb;

`ifdef PROOF_MLCOMB_ZSKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [255:0] modp_i = '0;
    logic         term_valid_i = 1'b0;
    logic         term_ready_o;
    logic [3:0]   term_coef_i = '0;
    logic [255:0] term_dat_i = '0;
    logic         term_last_i = 1'b0;
    logic         mstr_o;
    logic [3:0]   coef_o;
    logic [255:0] mdat_o;
    logic [255:0] modp_o;
    logic         mend_i = 1'b0;
    logic [255:0] mult_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [255:0] sum_o;
    logic [7:0]   term_cnt_o;

    proof_mlcomb dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .modp_i(modp_i),
        .term_valid_i(term_valid_i), .term_ready_o(term_ready_o),
        .term_coef_i(term_coef_i), .term_dat_i(term_dat_i), .term_last_i(term_last_i),
        .mstr_o(mstr_o), .coef_o(coef_o), .mdat_o(mdat_o), .modp_o(modp_o),
        .mend_i(mend_i), .mult_i(mult_i), .busy_o(busy_o), .done_o(done_o),
        .sum_o(sum_o), .term_cnt_o(term_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input bit ok,
                       input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] sum;
        int           cnt;
        int           pulses;
    } exp_t;
    exp_t sb[$];

    // Behavioural multiplier: result appears 4 cycles after mstr_o.
    int           mstr_cnt = 0;
    int           cd = 0;
    bit           rst_seen = 1'b0;
    logic [3:0]   cap_coef;
    logic [255:0] cap_dat;
    logic [255:0] cap_res;
    logic [263:0] wide;

    always @(negedge clk_i) begin
        mend_i = 1'b0;
        if (rst_i) rst_seen = 1'b1;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mend_i = 1'b1;
                mult_i = cap_res;
                if (!rst_seen) begin
                    chk("coef_stable", coef_o == cap_coef, 256'(coef_o), 256'(cap_coef));
                    chk("mdat_stable", mdat_o == cap_dat, mdat_o, cap_dat);
                end
            end
        end
        if (mstr_o) begin
            mstr_cnt++;
            rst_seen = 1'b0;
            cap_coef = coef_o;
            cap_dat  = mdat_o;
            wide     = ({260'd0, coef_o} * {8'd0, mdat_o}) % {8'd0, modp_o};
            cap_res  = wide[255:0];
            cd       = 4;
        end
    end

    // Monitor: pops one expected result for every done_o pulse.
    bit prev_done = 1'b0;
    always @(negedge clk_i) begin
        if (prev_done) begin
            chk("done_one_cycle", done_o == 1'b0, 256'(done_o), 256'd0);
            chk("busy_after_done", busy_o == 1'b0, 256'(busy_o), 256'd0);
        end
        prev_done = done_o;
        if (busy_o) begin
            chk("sum_below_p", sum_o < modp_o, sum_o, modp_o);
        end
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1'b0, 256'(done_o), 256'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn done sum=%0h cnt=%0d pulses=%0d", sum_o, term_cnt_o, mstr_cnt);
                chk("sum", sum_o == e.sum, sum_o, e.sum);
                chk("term_cnt", int'(term_cnt_o) == e.cnt, 256'(term_cnt_o), 256'(e.cnt));
                chk("mstr_pulses", mstr_cnt == e.pulses, 256'(mstr_cnt), 256'(e.pulses));
            end
        end
    end

    // Term table for the driver.
    logic [3:0]   tc [8];
    logic [255:0] td [8];

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, term_ready_o == 1'b0, 256'(term_ready_o), 256'd0);
        chk({tag, "_mstr"},  mstr_o == 1'b0, 256'(mstr_o), 256'd0);
        chk({tag, "_busy"},  busy_o == 1'b0, 256'(busy_o), 256'd0);
        chk({tag, "_done"},  done_o == 1'b0, 256'(done_o), 256'd0);
        chk({tag, "_sum"},   sum_o == '0, sum_o, 256'd0);
        chk({tag, "_cnt"},   term_cnt_o == '0, 256'(term_cnt_o), 256'd0);
        chk({tag, "_coef"},  coef_o == '0, 256'(coef_o), 256'd0);
        chk({tag, "_mdat"},  mdat_o == '0, mdat_o, 256'd0);
        chk({tag, "_modp"},  modp_o == '0, modp_o, 256'd0);
    endtask

    // Drive one combination of n terms and queue its expected result.
    // hold keeps term_valid_i high between terms; disturb pulses start_i
    // with a different modulus while the first term is in MWAIT.
    task automatic run(input logic [255:0] p, input int n, input bit hold,
                       input bit disturb, input logic [255:0] exp_sum);
        exp_t e;
        int   npulse = 0;
        int   to;
        for (int k = 0; k < n; k++) begin
            if (!(ZSKIP && tc[k] == 4'd0)) npulse++;
        end
        e.sum = exp_sum;
        e.cnt = n;
        e.pulses = mstr_cnt + npulse;
        sb.push_back(e);

        @(negedge clk_i);
        start_i = 1'b1;
        modp_i  = p;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("ready_after_start", term_ready_o == 1'b1, 256'(term_ready_o), 256'd1);
        chk("sum_cleared", sum_o == '0, sum_o, 256'd0);
        chk("cnt_cleared", term_cnt_o == '0, 256'(term_cnt_o), 256'd0);
        chk("modp_latched", modp_o == p, modp_o, p);

        for (int k = 0; k < n; k++) begin
            term_coef_i  = tc[k];
            term_dat_i   = td[k];
            term_last_i  = (k == n - 1);
            term_valid_i = 1'b1;
            to = 0;
            while (!term_ready_o && to < 200) begin
                @(negedge clk_i);
                to++;
            end
            if (to >= 200) begin
                chk("ready_timeout", 1'b0, 256'(to), 256'd200);
                return;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            term_valid_i = hold && (k != n - 1);
            chk("mstr_after_accept", mstr_o == !(ZSKIP && tc[k] == 4'd0),
                256'(mstr_o), 256'(!(ZSKIP && tc[k] == 4'd0)));
            chk("cnt_after_accept", int'(term_cnt_o) == k + 1,
                256'(term_cnt_o), 256'(k + 1));
            if (disturb && k == 0) begin
                @(negedge clk_i);
                start_i = 1'b1;
                modp_i  = 256'd29;
                @(negedge clk_i);
                start_i = 1'b0;
                modp_i  = p;
                chk("modp_kept", modp_o == p, modp_o, p);
            end
        end
        term_valid_i = 1'b0;
        to = 0;
        while (!done_o && to < 300) begin
            @(negedge clk_i);
            to++;
        end
        if (to >= 300) chk("done_timeout", 1'b0, 256'(to), 256'd300);
        @(negedge clk_i);
        chk("modp_final", modp_o == p, modp_o, p);
        chk("sum_held", sum_o == exp_sum, sum_o, exp_sum);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] bigp;
        logic [255:0] bigd;
        logic [255:0] bigs;
        int           to;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset_held");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("reset_idle");

        // 3*5 + 7*10 = 85 = 3*23 + 16
        tc[0] = 4'd3; td[0] = 256'd5;
        tc[1] = 4'd7; td[1] = 256'd10;
        run(256'd23, 2, 1'b0, 1'b0, 256'd16);

        // 22 + 1 wraps exactly to 0
        tc[0] = 4'd1; td[0] = 256'd22;
        tc[1] = 4'd1; td[1] = 256'd1;
        run(256'd23, 2, 1'b0, 1'b0, 256'd0);

        // valid held high: 2*11 + 5*20 + 15*22 = 452 = 19*23 + 15
        tc[0] = 4'd2;  td[0] = 256'd11;
        tc[1] = 4'd5;  td[1] = 256'd20;
        tc[2] = 4'd15; td[2] = 256'd22;
        run(256'd23, 3, 1'b1, 1'b0, 256'd15);

        // start_i with p=29 during MWAIT is ignored: 4*6 = 24 -> 1 mod 23
        tc[0] = 4'd4; td[0] = 256'd6;
        run(256'd23, 1, 1'b0, 1'b1, 256'd1);

        // Full-width p = 2^256-189; 15(p-1) + 15(p-1) = p-30 mod p (carry into bit 256)
        bigp = '1; bigp[7:0] = 8'h43;
        bigd = '1; bigd[7:0] = 8'h42;
        bigs = '1; bigs[7:0] = 8'h25;
        tc[0] = 4'd15; td[0] = bigd;
        tc[1] = 4'd15; td[1] = bigd;
        run(bigp, 2, 1'b0, 1'b0, bigs);

        // zero-coefficient term: 0*9 + 2*4 = 8
        tc[0] = 4'd0; td[0] = 256'd9;
        tc[1] = 4'd2; td[1] = 256'd4;
        run(256'd23, 2, 1'b0, 1'b0, 256'd8);

        // Reset during MWAIT, then the stale mend_i arrives and is ignored.
        @(negedge clk_i);
        start_i = 1'b1;
        modp_i  = 256'd23;
        @(negedge clk_i);
        start_i      = 1'b0;
        term_coef_i  = 4'd3;
        term_dat_i   = 256'd5;
        term_last_i  = 1'b1;
        term_valid_i = 1'b1;
        to = 0;
        while (!term_ready_o && to < 50) begin
            @(negedge clk_i);
            to++;
        end
        chk("rst_test_ready", term_ready_o == 1'b1, 256'(term_ready_o), 256'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        term_valid_i = 1'b0;
        chk("rst_test_mstr", mstr_o == 1'b1, 256'(mstr_o), 256'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        $display("txn reset during MWAIT");
        check_all_zero("reset_abort");
        repeat (6) @(negedge clk_i);
        check_all_zero("after_stale_mend");

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", sb.size() == 0, 256'(sb.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
